// File: rtl/id_ex_hazard_ctrl.sv
// Hazard/sequencing controller: load-use and HI/LO stalls, taken-branch squash for IF/ID, ID/EX, EX/MEM.
// Latency: control outputs are combinational (zero-cycle stall); HI/LO busy state and counter are registered.
// Backpressure: stall holds PC and IF/ID and injects an ID/EX bubble; optional stall counter under HAZARD_STALL_COUNT_EN.
module id_ex_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [4:0]  IDRs,
    input  logic [4:0]  IDRt,
    input  logic        IDUsesRt,
    input  logic        IDHiLoRead,
    input  logic        IDHiLoWrite,
    input  logic        EXMemRead,
    input  logic [4:0]  EXRt,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        EXMEMFlush,
    output logic        HiLoBusy,
    output logic [31:0] StallCount
);

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic busy;
    logic load_use;
    logic hilo_haz;
    logic stall;
    logic accept;
    logic squash;

    // Busy is forced low while reset is held so the reset cycle reports an idle HI/LO unit.
    assign busy     = Rst_n & (state == MUL_BUSY);
    assign HiLoBusy = busy;

    // Hazard terms; register 0 never carries a real dependency.
    assign load_use = EXMemRead & (EXRt != 5'd0) &
                      ((EXRt == IDRs) | (IDUsesRt & (EXRt == IDRt)));
    assign hilo_haz = busy & (IDHiLoRead | IDHiLoWrite);
    assign stall    = load_use | hilo_haz;

    // A HI/LO op leaves ID only when it is neither stalled nor squashed.
    assign accept   = IDHiLoWrite & ~stall & ~BranchTaken;
    // Branch while the op sits in EX kills it before it commits to HI/LO.
    assign squash   = BranchTaken & (cnt == LAT);

    // Pipeline control: reset, then branch squash, then stall, then free-running.
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        if (!Rst_n) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (BranchTaken) begin
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (stall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXFlush  = 1'b1;
        end
    end

    // HI/LO tracker: load MUL_LAT on accept, count down to idle, abort on squash or reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= MUL_BUSY;
                        cnt   <= LAT;
                    end
                end
                MUL_BUSY: begin
                    if (squash || (cnt <= ONE)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt - ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_cnt;

    // Count frozen-PC cycles outside reset, saturating at all-ones.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stall_cnt <= '0;
        end else if (!PCWrite && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign StallCount = stall_cnt;
`else
    assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
module tb_id_ex_hazard_ctrl;

    logic        Clk;
    logic        Rst_n;
    logic [4:0]  IDRs;
    logic [4:0]  IDRt;
    logic        IDUsesRt;
    logic        IDHiLoRead;
    logic        IDHiLoWrite;
    logic        EXMemRead;
    logic [4:0]  EXRt;
    logic        BranchTaken;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        IDEXFlush;
    logic        EXMEMFlush;
    logic        HiLoBusy;
    logic [31:0] StallCount;

    int n_tests = 0;
    int n_fail  = 0;

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, HiLoBusy}
    logic [5:0] ctl;
    assign ctl = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, HiLoBusy};

    localparam logic [5:0] C_RESET  = 6'b001110;
    localparam logic [5:0] C_RUN    = 6'b110000;
    localparam logic [5:0] C_RUN_B  = 6'b110001;
    localparam logic [5:0] C_STALL  = 6'b000100;
    localparam logic [5:0] C_STALLB = 6'b000101;
    localparam logic [5:0] C_BR     = 6'b111110;
    localparam logic [5:0] C_BR_B   = 6'b111111;

    id_ex_hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .IDRs        (IDRs),
        .IDRt        (IDRt),
        .IDUsesRt    (IDUsesRt),
        .IDHiLoRead  (IDHiLoRead),
        .IDHiLoWrite (IDHiLoWrite),
        .EXMemRead   (EXMemRead),
        .EXRt        (EXRt),
        .BranchTaken (BranchTaken),
        .PCWrite     (PCWrite),
        .IFIDWrite   (IFIDWrite),
        .IFIDFlush   (IFIDFlush),
        .IDEXFlush   (IDEXFlush),
        .EXMEMFlush  (EXMEMFlush),
        .HiLoBusy    (HiLoBusy),
        .StallCount  (StallCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        IDRs        = 5'd0;
        IDRt        = 5'd0;
        IDUsesRt    = 1'b0;
        IDHiLoRead  = 1'b0;
        IDHiLoWrite = 1'b0;
        EXMemRead   = 1'b0;
        EXRt        = 5'd0;
        BranchTaken = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        Rst_n       = 1'b0;
        EXMemRead   = 1'b1;
        EXRt        = 5'd4;
        IDRs        = 5'd4;
        #1;
        if (ctl !== C_RESET) begin n_fail++; $display("FAIL reset_outputs got %b exp %b", ctl, C_RESET); end
        n_tests++;
        step();
        step();
        Rst_n = 1'b1;
        clear_inputs();
        #1;
        if (ctl !== C_RUN) begin n_fail++; $display("FAIL post_reset got %b exp %b", ctl, C_RUN); end
        n_tests++;
        if (StallCount !== 32'd0) begin n_fail++; $display("FAIL reset_stallcount got %0d exp 0", StallCount); end
        n_tests++;
    endtask

    task automatic test_load_use();
        clear_inputs();
        EXMemRead = 1'b1; EXRt = 5'd8; IDRs = 5'd8;
        #1;
        if (ctl !== C_STALL) begin n_fail++; $display("FAIL lu_rs got %b exp %b", ctl, C_STALL); end
        n_tests++;
        step();
        EXMemRead = 1'b0;
        #1;
        if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_rs_release got %b exp %b", ctl, C_RUN); end
        n_tests++;
        step();
        clear_inputs();
        EXMemRead = 1'b1; EXRt = 5'd9; IDRt = 5'd9; IDRs = 5'd3; IDUsesRt = 1'b1;
        #1;
        if (ctl !== C_STALL) begin n_fail++; $display("FAIL lu_rt got %b exp %b", ctl, C_STALL); end
        n_tests++;
        step();
        clear_inputs();
    endtask

    task automatic test_no_stall();
        clear_inputs();
        EXMemRead = 1'b1; EXRt = 5'd0; IDRs = 5'd0;
        #1;
        if (ctl !== C_RUN) begin n_fail++; $display("FAIL r0_no_stall got %b exp %b", ctl, C_RUN); end
        n_tests++;
        EXRt = 5'd9; IDRt = 5'd9; IDRs = 5'd3; IDUsesRt = 1'b0;
        #1;
        if (ctl !== C_RUN) begin n_fail++; $display("FAIL rt_unused_no_stall got %b exp %b", ctl, C_RUN); end
        n_tests++;
        step();
        clear_inputs();
    endtask

    task automatic test_hilo_seq();
        clear_inputs();
        IDHiLoWrite = 1'b1;
        #1;
        if (ctl !== C_RUN) begin n_fail++; $display("FAIL mult_accept got %b exp %b", ctl, C_RUN); end
        n_tests++;
        step();
        IDHiLoWrite = 1'b0; IDHiLoRead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ctl !== C_STALLB) begin n_fail++; $display("FAIL hilo_busy_cyc%0d got %b exp %b", i, ctl, C_STALLB); end
            n_tests++;
            step();
        end
        #1;
        if (ctl !== C_RUN) begin n_fail++; $display("FAIL hilo_release got %b exp %b", ctl, C_RUN); end
        n_tests++;
        step();
        clear_inputs();
    endtask

    task automatic test_squash();
        clear_inputs();
        IDHiLoWrite = 1'b1;
        step();
        IDHiLoWrite = 1'b0; BranchTaken = 1'b1;
        #1;
        if (ctl !== C_BR_B) begin n_fail++; $display("FAIL squash_cnt4 got %b exp %b", ctl, C_BR_B); end
        n_tests++;
        step();
        BranchTaken = 1'b0;
        #1;
        if (ctl !== C_RUN) begin n_fail++; $display("FAIL squash_cnt4_idle got %b exp %b", ctl, C_RUN); end
        n_tests++;
        IDHiLoWrite = 1'b1;
        step();
        IDHiLoWrite = 1'b0;
        step();
        step();
        BranchTaken = 1'b1;
        #1;
        if (ctl !== C_BR_B) begin n_fail++; $display("FAIL branch_cnt2 got %b exp %b", ctl, C_BR_B); end
        n_tests++;
        step();
        BranchTaken = 1'b0;
        #1;
        if (ctl !== C_RUN_B) begin n_fail++; $display("FAIL branch_cnt2_cnt1 got %b exp %b", ctl, C_RUN_B); end
        n_tests++;
        step();
        #1;
        if (ctl !== C_RUN) begin n_fail++; $display("FAIL branch_cnt2_done got %b exp %b", ctl, C_RUN); end
        n_tests++;
        clear_inputs();
    endtask

    task automatic test_priority();
        clear_inputs();
        EXMemRead = 1'b1; EXRt = 5'd8; IDRs = 5'd8; BranchTaken = 1'b1;
        #1;
        if (ctl !== C_BR) begin n_fail++; $display("FAIL branch_over_lu got %b exp %b", ctl, C_BR); end
        n_tests++;
        step();
        clear_inputs();
        IDHiLoWrite = 1'b1;
        step();
        IDHiLoWrite = 1'b0;
        step();
        Rst_n = 1'b0;
        #1;
        if (ctl !== C_RESET) begin n_fail++; $display("FAIL reset_mid_cnt3 got %b exp %b", ctl, C_RESET); end
        n_tests++;
        step();
        Rst_n = 1'b1;
        IDHiLoRead = 1'b1;
        #1;
        if (ctl !== C_RUN) begin n_fail++; $display("FAIL reset_mid_after got %b exp %b", ctl, C_RUN); end
        n_tests++;
        step();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        IDHiLoWrite = 1'b1;
        #1;
        if (ctl !== C_RUN) begin n_fail++; $display("FAIL b2b_first got %b exp %b", ctl, C_RUN); end
        n_tests++;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ctl !== C_STALLB) begin n_fail++; $display("FAIL b2b_hold_cyc%0d got %b exp %b", i, ctl, C_STALLB); end
            n_tests++;
            step();
        end
        #1;
        if (ctl !== C_RUN) begin n_fail++; $display("FAIL b2b_second_accept got %b exp %b", ctl, C_RUN); end
        n_tests++;
        step();
        IDHiLoWrite = 1'b0;
        #1;
        if (ctl !== C_RUN_B) begin n_fail++; $display("FAIL b2b_second_busy got %b exp %b", ctl, C_RUN_B); end
        n_tests++;
        do_reset();
    endtask

    task automatic test_stall_count();
        logic [31:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            EXMemRead = 1'b1; EXRt = 5'd5; IDRs = 5'd5;
            step();
            clear_inputs();
            step();
        end
        IDHiLoWrite = 1'b1;
        step();
        IDHiLoWrite = 1'b0; IDHiLoRead = 1'b1;
        repeat (4) step();
        clear_inputs();
        step();
`ifdef HAZARD_STALL_COUNT_EN
        exp_cnt = 32'd7;
`else
        exp_cnt = 32'd0;
`endif
        #1;
        if (StallCount !== exp_cnt) begin n_fail++; $display("FAIL stall_count got %0d exp %0d", StallCount, exp_cnt); end
        n_tests++;
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        #1;
        if (StallCount !== 32'd0) begin n_fail++; $display("FAIL stall_count_clear got %0d exp 0", StallCount); end
        n_tests++;
    endtask

    initial begin
        clear_inputs();
        Rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_no_stall();
        test_hilo_seq();
        test_squash();
        test_priority();
        test_back_to_back();
        test_stall_count();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
